fetch_decode_stage: RTL and testbench
=====================================

# fetch_decode_stage

Front end of the pipelined ARM-subset core. Holds the program counter and the IF/ID pipeline register, and decodes the latched instruction into register-file read/write addresses. It produces the R15 value (PC+8) consumed directly by the register file, and the extended immediate. It applies stall, flush and branch-redirect controls from the hazard unit and the execute stage.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- CLK  in  1  system clock; all state updates on rising edge.
- RST  in  1  asynchronous, active-high reset.
- InstrF  in  32  instruction word read from instruction memory at PCF.
- StallD  in  1  holds PC and IF/ID register.
- FlushD  in  1  inserts a bubble into IF/ID.
- BranchTakenE  in  1  execute-stage redirect request.
- BranchTargetE  in  32  redirect address.
- PCF  out  32  fetch address to instruction memory.
- InstrD  out  32  latched instruction.
- PCD  out  32  address of InstrD.
- ValidD  out  1  InstrD holds a real instruction.
- A1, A2, A3  out  4 each  register-file read/read/write addresses.
- RegWriteD  out  1  decoded write enable for A3.
- R15  out  32  PCD + 8, fed to the register file R15 input.
- ImmExtD  out  32  extended immediate.

## Operation
- Clock and reset: one clock; reset is asynchronous and active-high.
- Sequential update priority, highest first: RST > BranchTakenE > FlushD/StallD > normal.
- RST: PCF=RESET_PC, PCD=RESET_PC, InstrD=0, ValidD=0.
- BranchTakenE=1:
  - PCF<=BranchTargetE.
  - IF/ID cleared: ValidD<=0, InstrD<=0.
  - Overrides StallD and FlushD.
- FlushD=1, StallD=0: PCF<=PCF+4; IF/ID cleared.
- FlushD=1, StallD=1: PCF held; IF/ID cleared.
- StallD=1 alone: PCF, PCD, InstrD, ValidD all held.
- Normal: InstrD<=InstrF, PCD<=PCF, ValidD<=1, PCF<=PCF+4.
- PC arithmetic is modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0.
- Decode is combinational from InstrD. With ValidD=0, all decode outputs are forced to 0: A1, A2, A3, RegWriteD, ImmExtD.
- Decode uses Op=InstrD[27:26]:
  - 00 data-processing:
    - A1=[19:16], A2=[3:0], A3=[15:12].
    - RegWriteD=1 except opcode [24:21] in {1000,1001,1010,1011}.
    - ImmExtD = {24'b0,[7:0]} rotated right by 2*[11:8].
  - 01 memory:
    - A1=[19:16], A2=[15:12], A3=[15:12].
    - RegWriteD=[20] (load).
    - ImmExtD = {20'b0,[11:0]}.
  - 10 branch:
    - A1=15, A2=0, A3=14.
    - RegWriteD per Configuration.
    - ImmExtD = sign-extended [23:0] shifted left 2.
  - 11: undefined; A1=A2=A3=0, RegWriteD=0, ImmExtD=0.
- Condition field [31:28] is not evaluated here; it passes through in InstrD.
- R15 = PCD+8 always, including when ValidD=0.

## Timing
- PCF changes only on rising CLK, or immediately on RST assertion.
- Fetch-to-decode latency is 1 cycle: InstrF sampled at edge n appears on InstrD after edge n.
- Decode outputs and R15 are valid within the same cycle InstrD/PCD update. They are stable before the register file's falling-edge write.
- Branch penalty: the instruction fetched in the redirect cycle is discarded. The first target instruction reaches decode 2 edges after BranchTakenE is sampled.
- RST deasserted mid-stream: the first edge after release captures InstrF at RESET_PC.

## Configuration
- BRANCH_LINK_EN defined:
  - Op=10 with [24]=1 (BL) gives RegWriteD=1, A3=14.
  - Execute computes the link data as R15-4.
- BRANCH_LINK_EN undefined: every Op=10 gives RegWriteD=0; bit 24 is ignored.

## Test plan
- Reset with RESET_PC=32'h100, then release: PCF=32'h100, ValidD=0, R15=32'h108. After 1 edge, PCD=32'h100, ValidD=1, PCF=32'h104.
- InstrF=32'hE081_2003 (ADD R2,R1,R3) -> A1=1, A2=3, A3=2, RegWriteD=1. InstrF=32'hE351_0000 (CMP) -> RegWriteD=0.
- InstrF=32'hE591_2004 (LDR) -> A1=1, A3=2, RegWriteD=1, ImmExtD=4. InstrF=32'hE3A0_02FF (MOV imm rot 2) -> ImmExtD=32'hF000_000F.
- StallD=1 for 3 cycles, then FlushD=1 with StallD=1 -> PCF and InstrD frozen during the stall; after the flush edge ValidD=0, PCF unchanged.
- BranchTakenE=1, BranchTargetE=32'h40, with StallD=1 -> next PCF=32'h40, ValidD=0. One edge later PCD=32'h40, ValidD=1.
- InstrF=32'hEBFF_FFFE (BL -2) -> ImmExtD=32'hFFFF_FFF8, A3=14, RegWriteD=1 with BRANCH_LINK_EN and 0 without.

Source files
------------

// File: rtl/fetch_decode_stage.sv
// fetch_decode_stage: program counter, IF/ID pipeline register and
// combinational decode of register addresses and extended immediate.
// Optional feature macro: BRANCH_LINK_EN (BL writes the link register R14).
module fetch_decode_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] InstrF,
    input  logic        StallD,
    input  logic        FlushD,
    input  logic        BranchTakenE,
    input  logic [31:0] BranchTargetE,
    output logic [31:0] PCF,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic        ValidD,
    output logic [3:0]  A1,
    output logic [3:0]  A2,
    output logic [3:0]  A3,
    output logic        RegWriteD,
    output logic [31:0] R15,
    output logic [31:0] ImmExtD
);

    logic [31:0] r_pcf;
    logic [31:0] r_pcd;
    logic [31:0] r_instr;
    logic        r_valid;

    logic [3:0]  w_a1;
    logic [3:0]  w_a2;
    logic [3:0]  w_a3;
    logic        w_rw;
    logic [31:0] w_imm;

    // Rotate right; the 64-bit concatenation avoids a shift-by-32 corner case.
    function automatic logic [31:0] ror32(input logic [31:0] v, input logic [4:0] sh);
        logic [63:0] w;
        w = {v, v} >> sh;
        return w[31:0];
    endfunction

    // Program counter: redirect beats stall; a flush alone still advances.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_pcf <= RESET_PC;
        end else if (BranchTakenE) begin
            r_pcf <= BranchTargetE;
        end else if (!StallD) begin
            r_pcf <= r_pcf + 32'd4;
        end
    end

    // IF/ID register: redirect or flush inserts a bubble, stall holds, else capture.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_pcd   <= RESET_PC;
            r_instr <= 32'd0;
            r_valid <= 1'b0;
        end else if (BranchTakenE || FlushD) begin
            r_instr <= 32'd0;
            r_valid <= 1'b0;
        end else if (!StallD) begin
            r_pcd   <= r_pcf;
            r_instr <= InstrF;
            r_valid <= 1'b1;
        end
    end

    // Decode by major opcode class; bubbles produce all-zero decode outputs.
    always_comb begin
        w_a1  = 4'd0;
        w_a2  = 4'd0;
        w_a3  = 4'd0;
        w_rw  = 1'b0;
        w_imm = 32'd0;
        if (r_valid) begin
            unique case (r_instr[27:26])
                2'b00: begin
                    w_a1  = r_instr[19:16];
                    w_a2  = r_instr[3:0];
                    w_a3  = r_instr[15:12];
                    // TST/TEQ/CMP/CMN (opcode 10xx) only set flags.
                    w_rw  = (r_instr[24:23] != 2'b10);
                    w_imm = ror32({24'd0, r_instr[7:0]}, {r_instr[11:8], 1'b0});
                end
                2'b01: begin
                    w_a1  = r_instr[19:16];
                    w_a2  = r_instr[15:12];
                    w_a3  = r_instr[15:12];
                    w_rw  = r_instr[20];
                    w_imm = {20'd0, r_instr[11:0]};
                end
                2'b10: begin
                    w_a1  = 4'd15;
                    w_a2  = 4'd0;
                    w_a3  = 4'd14;
`ifdef BRANCH_LINK_EN
                    w_rw  = r_instr[24];
`else
                    w_rw  = 1'b0;
`endif
                    w_imm = {{6{r_instr[23]}}, r_instr[23:0], 2'b00};
                end
                default: begin
                    w_a1  = 4'd0;
                    w_a2  = 4'd0;
                    w_a3  = 4'd0;
                    w_rw  = 1'b0;
                    w_imm = 32'd0;
                end
            endcase
        end
    end

    assign PCF       = r_pcf;
    assign PCD       = r_pcd;
    assign InstrD    = r_instr;
    assign ValidD    = r_valid;
    assign A1        = w_a1;
    assign A2        = w_a2;
    assign A3        = w_a3;
    assign RegWriteD = w_rw;
    assign ImmExtD   = w_imm;
    // R15 reads as the address of the decoding instruction plus 8.
    assign R15       = r_pcd + 32'd8;

endmodule

// File: tb/tb_fetch_decode_stage.sv
// Scoreboard bench for fetch_decode_stage: the driver pushes hand-computed
// expected state for each edge, a monitor pops and compares after the edge.
module tb_fetch_decode_stage;

    typedef struct packed {
        logic        valid;
        logic [31:0] pcf;
        logic [31:0] pcd;
        logic [31:0] instr;
        logic [3:0]  a1;
        logic [3:0]  a2;
        logic [3:0]  a3;
        logic        rw;
        logic [31:0] imm;
        logic [31:0] r15;
    } exp_t;

    logic        CLK = 1'b0;
    logic        RST;
    logic [31:0] InstrF;
    logic        StallD, FlushD, BranchTakenE;
    logic [31:0] BranchTargetE;
    logic [31:0] PCF, InstrD, PCD, R15, ImmExtD;
    logic        ValidD, RegWriteD;
    logic [3:0]  A1, A2, A3;

    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t q[$];

`ifdef BRANCH_LINK_EN
    localparam logic BL_RW = 1'b1;
`else
    localparam logic BL_RW = 1'b0;
`endif

    fetch_decode_stage #(.RESET_PC(32'h100)) dut (
        .CLK(CLK), .RST(RST), .InstrF(InstrF), .StallD(StallD), .FlushD(FlushD),
        .BranchTakenE(BranchTakenE), .BranchTargetE(BranchTargetE),
        .PCF(PCF), .InstrD(InstrD), .PCD(PCD), .ValidD(ValidD),
        .A1(A1), .A2(A2), .A3(A3), .RegWriteD(RegWriteD), .R15(R15), .ImmExtD(ImmExtD)
    );

    always #5 CLK = ~CLK;

    // Monitor: compare DUT state just after each rising edge against the queue.
    always @(posedge CLK) begin
        #1;
        if (q.size() > 0) begin
            exp_t e, a;
            e = q.pop_front();
            a = '{ValidD, PCF, PCD, InstrD, A1, A2, A3, RegWriteD, ImmExtD, R15};
            n_checks++;
            if (a === e) n_pass++;
            else $display("FAIL sb[%0d] got v=%b pcf=%h pcd=%h ins=%h a=%h/%h/%h rw=%b imm=%h r15=%h want v=%b pcf=%h pcd=%h ins=%h a=%h/%h/%h rw=%b imm=%h r15=%h",
                          n_checks, a.valid, a.pcf, a.pcd, a.instr, a.a1, a.a2, a.a3, a.rw, a.imm, a.r15,
                          e.valid, e.pcf, e.pcd, e.instr, e.a1, e.a2, e.a3, e.rw, e.imm, e.r15);
        end
    end

    // Drive one cycle of inputs at the falling edge and queue the post-edge expectation.
    task automatic step(input logic rst_i, input logic [31:0] ins_i, input logic st, input logic fl,
                        input logic br, input logic [31:0] tgt,
                        input logic v, input logic [31:0] pcf, input logic [31:0] pcd,
                        input logic [31:0] ins, input logic [3:0] a1, input logic [3:0] a2,
                        input logic [3:0] a3, input logic rw, input logic [31:0] imm,
                        input logic [31:0] r15);
        RST = rst_i; InstrF = ins_i; StallD = st; FlushD = fl;
        BranchTakenE = br; BranchTargetE = tgt;
        q.push_back('{v, pcf, pcd, ins, a1, a2, a3, rw, imm, r15});
        @(negedge CLK);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1'b1; InstrF = 32'd0; StallD = 1'b0; FlushD = 1'b0;
        BranchTakenE = 1'b0; BranchTargetE = 32'd0;
        @(negedge CLK);
        //    rst instrF        st fl br tgt            v  PCF           PCD           InstrD        A1 A2 A3 rw imm           R15
        step(1, 32'h0,          0, 0, 0, 32'h0,         0, 32'h100,      32'h100,      32'h0,        0, 0, 0, 0, 32'h0,        32'h108);
        step(0, 32'hE081_2003, 0, 0, 0, 32'h0,         1, 32'h104,      32'h100,      32'hE081_2003, 1, 3, 2, 1, 32'h3,       32'h108);
        step(0, 32'hE351_0000, 0, 0, 0, 32'h0,         1, 32'h108,      32'h104,      32'hE351_0000, 1, 0, 0, 0, 32'h0,       32'h10C);
        step(0, 32'hE591_2004, 0, 0, 0, 32'h0,         1, 32'h10C,      32'h108,      32'hE591_2004, 1, 2, 2, 1, 32'h4,       32'h110);
        step(0, 32'hE3A0_02FF, 0, 0, 0, 32'h0,         1, 32'h110,      32'h10C,      32'hE3A0_02FF, 0, 15, 0, 1, 32'hF000_000F, 32'h114);
        step(0, 32'hEBFF_FFFE, 0, 0, 0, 32'h0,         1, 32'h114,      32'h110,      32'hEBFF_FFFE, 15, 0, 14, BL_RW, 32'hFFFF_FFF8, 32'h118);
        // three stalled cycles hold everything
        for (int i = 0; i < 3; i++)
            step(0, 32'hE081_2003, 1, 0, 0, 32'h0,     1, 32'h114,      32'h110,      32'hEBFF_FFFE, 15, 0, 14, BL_RW, 32'hFFFF_FFF8, 32'h118);
        // flush while stalled: bubble, PC held
        step(0, 32'hE081_2003, 1, 1, 0, 32'h0,         0, 32'h114,      32'h110,      32'h0,        0, 0, 0, 0, 32'h0,        32'h118);
        step(0, 32'hE081_2003, 0, 0, 0, 32'h0,         1, 32'h118,      32'h114,      32'hE081_2003, 1, 3, 2, 1, 32'h3,       32'h11C);
        // redirect overrides stall
        step(0, 32'hE591_2004, 1, 0, 1, 32'h40,        0, 32'h40,       32'h114,      32'h0,        0, 0, 0, 0, 32'h0,        32'h11C);
        step(0, 32'hE351_0000, 0, 0, 0, 32'h0,         1, 32'h44,       32'h40,       32'hE351_0000, 1, 0, 0, 0, 32'h0,       32'h48);
        // flush without stall: bubble, PC advances
        step(0, 32'hE081_2003, 0, 1, 0, 32'h0,         0, 32'h48,       32'h40,       32'h0,        0, 0, 0, 0, 32'h0,        32'h48);
        // redirect overrides flush; PC wraps past the top of memory
        step(0, 32'hE081_2003, 0, 1, 1, 32'hFFFF_FFFC, 0, 32'hFFFF_FFFC, 32'h40,       32'h0,        0, 0, 0, 0, 32'h0,        32'h48);
        step(0, 32'hE591_2004, 0, 0, 0, 32'h0,         1, 32'h0,        32'hFFFF_FFFC, 32'hE591_2004, 1, 2, 2, 1, 32'h4,       32'h4);
        step(0, 32'hFC00_0000, 0, 0, 0, 32'h0,         1, 32'h4,        32'h0,        32'hFC00_0000, 0, 0, 0, 0, 32'h0,       32'h8);
        // asynchronous reset mid-stream takes effect before any edge
        RST = 1'b1;
        #1;
        n_checks++;
        if (PCF === 32'h100 && ValidD === 1'b0 && PCD === 32'h100) n_pass++;
        else $display("FAIL async_rst got pcf=%h v=%b pcd=%h want pcf=00000100 v=0 pcd=00000100", PCF, ValidD, PCD);
        step(1, 32'hE081_2003, 0, 0, 0, 32'h0,         0, 32'h100,      32'h100,      32'h0,        0, 0, 0, 0, 32'h0,        32'h108);
        step(0, 32'hE081_2003, 0, 0, 0, 32'h0,         1, 32'h104,      32'h100,      32'hE081_2003, 1, 3, 2, 1, 32'h3,       32'h108);
        repeat (2) @(negedge CLK);
        n_checks++;
        if (q.size() == 0) n_pass++;
        else $display("FAIL sb_drain got %0d pending want 0", q.size());
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
